// File: rtl/lbp_stream_engine_if.sv
// Handshake bundle between the LBP engine, its gray-image source and its code sink.
// The master side is the engine; the slave side is the image source plus the code sink.
interface lbp_stream_engine_if #(
  parameter int unsigned XW    = 7,
  parameter int unsigned YW    = 7,
  parameter int unsigned PIX_W = 8
);
  logic                 gray_req;
  logic                 gray_ready;
  logic [XW+YW-1:0]     gray_addr;
  logic [PIX_W-1:0]     gray_data;
  logic                 lbp_valid;
  logic                 lbp_ready;
  logic [XW+YW-1:0]     lbp_addr;
  logic [7:0]           lbp_data;

  modport master (
    output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
    input  gray_ready, gray_data, lbp_ready
  );

  modport slave (
    input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
    output gray_ready, gray_data, lbp_ready
  );
endinterface

// File: rtl/lbp_stream_engine.sv
// Streaming LBP engine: fetches each interior pixel's 3x3 neighbourhood and emits one
// 8-bit code per interior pixel in raster order, reusing two window columns along a row.
module lbp_stream_engine #(
  parameter int unsigned XW    = 7,
  parameter int unsigned YW    = 7,
  parameter int unsigned PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] thr,
  output logic             finish,
  lbp_stream_engine_if.master bus
);
  localparam int unsigned AW = XW + YW;
  localparam logic [XW-1:0] X_LAST = XW'((1 << XW) - 2);
  localparam logic [YW-1:0] Y_LAST = YW'((1 << YW) - 2);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_SHIFT, S_CALC, S_OUT, S_DONE} state_t;

  state_t           r_state;
  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic [XW-1:0]    r_rd_x;
  logic [YW-1:0]    r_rd_y;
  logic [1:0]       r_row;
  logic [1:0]       r_col;
  logic [PIX_W-1:0] r_win [9];
  logic [PIX_W-1:0] r_thr;
  logic             r_gray_req;
  logic             r_lbp_valid;
  logic [AW-1:0]    r_lbp_addr;
  logic [7:0]       r_lbp_data;
  logic             r_finish;

  logic             w_beat;
  logic [3:0]       w_idx;
  logic [PIX_W:0]   w_ref;
  logic [7:0]       w_code;

  assign w_beat = r_gray_req & bus.gray_ready;
  assign w_idx  = 4'(r_row) * 4'd3 + 4'(r_col);

  // Centre plus threshold kept one bit wider so a large threshold never wraps
  assign w_ref     = {1'b0, r_win[4]} + {1'b0, r_thr};
  assign w_code[0] = {1'b0, r_win[0]} >= w_ref;
  assign w_code[1] = {1'b0, r_win[1]} >= w_ref;
  assign w_code[2] = {1'b0, r_win[2]} >= w_ref;
  assign w_code[3] = {1'b0, r_win[3]} >= w_ref;
  assign w_code[4] = {1'b0, r_win[5]} >= w_ref;
  assign w_code[5] = {1'b0, r_win[6]} >= w_ref;
  assign w_code[6] = {1'b0, r_win[7]} >= w_ref;
  assign w_code[7] = {1'b0, r_win[8]} >= w_ref;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_x         <= XW'(1);
      r_y         <= YW'(1);
      r_rd_x      <= '0;
      r_rd_y      <= '0;
      r_row       <= 2'd0;
      r_col       <= 2'd0;
      r_win       <= '{default: '0};
      r_thr       <= '0;
      r_gray_req  <= 1'b0;
      r_lbp_valid <= 1'b0;
      r_lbp_addr  <= '0;
      r_lbp_data  <= '0;
      r_finish    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.gray_ready) begin
            r_thr      <= thr;
            r_rd_x     <= r_x - XW'(1);
            r_rd_y     <= r_y - YW'(1);
            r_row      <= 2'd0;
            r_col      <= 2'd0;
            r_gray_req <= 1'b1;
            r_state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_beat) begin
            r_win[w_idx] <= bus.gray_data;
            if (r_row == 2'd2 && r_col == 2'd2) begin
              r_gray_req <= 1'b0;
              r_state    <= S_CALC;
            end else if (r_col == 2'd2) begin
              r_col  <= 2'd0;
              r_row  <= r_row + 2'd1;
              r_rd_x <= r_x - XW'(1);
              r_rd_y <= r_rd_y + YW'(1);
            end else begin
              r_col  <= r_col + 2'd1;
              r_rd_x <= r_rd_x + XW'(1);
            end
          end
        end
        S_SHIFT: begin
          // Only the new right-hand column is fetched; r_col stays at 2
          if (w_beat) begin
            r_win[w_idx] <= bus.gray_data;
            if (r_row == 2'd2) begin
              r_gray_req <= 1'b0;
              r_state    <= S_CALC;
            end else begin
              r_row  <= r_row + 2'd1;
              r_rd_y <= r_rd_y + YW'(1);
            end
          end
        end
        S_CALC: begin
          r_lbp_data  <= w_code;
          r_lbp_addr  <= {r_y, r_x};
          r_lbp_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (bus.lbp_ready) begin
            r_lbp_valid <= 1'b0;
            if (r_x != X_LAST) begin
              r_win[0]   <= r_win[1];
              r_win[1]   <= r_win[2];
              r_win[3]   <= r_win[4];
              r_win[4]   <= r_win[5];
              r_win[6]   <= r_win[7];
              r_win[7]   <= r_win[8];
              r_x        <= r_x + XW'(1);
              r_rd_x     <= r_x + XW'(2);
              r_rd_y     <= r_y - YW'(1);
              r_row      <= 2'd0;
              r_col      <= 2'd2;
              r_gray_req <= 1'b1;
              r_state    <= S_SHIFT;
            end else if (r_y != Y_LAST) begin
              r_x        <= XW'(1);
              r_y        <= r_y + YW'(1);
              r_rd_x     <= '0;
              r_rd_y     <= r_y;
              r_row      <= 2'd0;
              r_col      <= 2'd0;
              r_gray_req <= 1'b1;
              r_state    <= S_FILL;
            end else begin
              r_finish <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gray_req  = r_gray_req;
  assign bus.gray_addr = {r_rd_y, r_rd_x};
  assign bus.lbp_valid = r_lbp_valid;
  assign bus.lbp_addr  = r_lbp_addr;
  assign bus.lbp_data  = r_lbp_data;
  assign finish        = r_finish;
endmodule

// File: tb/tb_lbp_stream_engine.sv
// Bench for lbp_stream_engine on an 8x16 image: scenario tasks compared against a
// neighbourhood-loop reference model, with random images, thresholds and handshake stalls.
`timescale 1ns/1ps
module tb_lbp_stream_engine;
  localparam int unsigned XW    = 3;
  localparam int unsigned YW    = 4;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned AW    = XW + YW;
  localparam int IMG_W  = 1 << XW;
  localparam int IMG_H  = 1 << YW;
  localparam int NOUT   = (IMG_W - 2) * (IMG_H - 2);
  localparam int BUDGET = 30000;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } out_t;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic [PIX_W-1:0] thr   = '0;
  logic             finish;

  always #5 clk = ~clk;

  lbp_stream_engine_if #(.XW(XW), .YW(YW), .PIX_W(PIX_W)) bif ();

  lbp_stream_engine #(.XW(XW), .YW(YW), .PIX_W(PIX_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .thr    (thr),
    .finish (finish),
    .bus    (bif)
  );

  logic [PIX_W-1:0] img [IMG_H][IMG_W];
  int   src_mode  = 1;   // 0 never ready, 1 always ready, 2 random
  int   sink_mode = 1;
  logic rnd_g = 1'b1;
  logic rnd_l = 1'b1;

  assign bif.gray_ready = (src_mode == 1) || (src_mode == 2 && rnd_g);
  assign bif.lbp_ready  = (sink_mode == 1) || (sink_mode == 2 && rnd_l);
  assign bif.gray_data  = img[bif.gray_addr[AW-1:XW]][bif.gray_addr[XW-1:0]];

  initial forever begin
    @(negedge clk);
    rnd_g = ($urandom_range(0, 3) != 0);
    rnd_l = ($urandom_range(0, 1) != 0);
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   req_first = -1;
  int   valid_cyc [$];
  int   viol_rd   = 0;
  int   viol_hold = 0;
  out_t got_q [$];
  out_t exp_q [$];
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr  = '0;

  // Edge monitor: collects accepted codes and protocol observations
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      if (bif.lbp_valid && bif.lbp_ready) begin
        got_q.push_back(out_t'({bif.lbp_addr, bif.lbp_data}));
        valid_cyc.push_back(cyc);
      end
      if (bif.lbp_valid && bif.gray_req) viol_rd++;
      if (prev_stall && bif.gray_addr != prev_addr) viol_hold++;
      if (bif.gray_req && req_first < 0) req_first = cyc;
      prev_stall = bif.gray_req && !bif.gray_ready;
      prev_addr  = bif.gray_addr;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic fill_flat(input logic [7:0] v);
    foreach (img[y, x]) img[y][x] = v;
  endtask

  task automatic fill_rand();
    foreach (img[y, x]) img[y][x] = 8'($urandom);
  endtask

  // Reference: every interior pixel, neighbours in raster order, integer compare
  task automatic build_exp(input int t);
    exp_q.delete();
    for (int y = 1; y <= IMG_H - 2; y++) begin
      for (int x = 1; x <= IMG_W - 2; x++) begin
        int k;
        logic [7:0] code;
        k = 0;
        code = '0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (dy != 0 || dx != 0) begin
              if (int'(img[y+dy][x+dx]) >= int'(img[y][x]) + t) code = code | 8'(1 << k);
              k++;
            end
          end
        end
        exp_q.push_back(out_t'({AW'(y * IMG_W + x), code}));
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    got_q.delete();
    valid_cyc.delete();
    req_first = -1;
    viol_rd   = 0;
    viol_hold = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Reset, let the engine latch t, then scramble thr to prove it is only sampled once
  task automatic start_frame(input logic [7:0] t);
    bit seen;
    build_exp(int'(t));
    thr = t;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (bif.gray_req) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL start: gray_req got 0 need 1 within 200 cycles");
    end
    thr = ~t;
  endtask

  task automatic finish_and_compare(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < BUDGET && !done; i++) begin
      @(posedge clk); #1;
      done = finish;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s finish_timeout: got finish 0 need 1 within %0d cycles", name, BUDGET);
    end
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if ({finish, bif.lbp_valid, bif.gray_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s done_state: got finish/valid/req %b need 100", name,
               {finish, bif.lbp_valid, bif.gray_req});
    end
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s out_count: got %0d need %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (i >= got_q.size()) begin
        n_fail++;
        $display("FAIL %s out[%0d]: got nothing need addr %0d data %02h", name, i,
                 exp_q[i].addr, exp_q[i].data);
      end else if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s out[%0d]: got addr %0d data %02h need addr %0d data %02h", name, i,
                 got_q[i].addr, got_q[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    n_tests++;
    if (viol_rd != 0) begin
      n_fail++;
      $display("FAIL %s read_during_out: got %0d cycles need 0", name, viol_rd);
    end
    n_tests++;
    if (viol_hold != 0) begin
      n_fail++;
      $display("FAIL %s addr_hold_on_stall: got %0d changes need 0", name, viol_hold);
    end
  endtask

  task automatic test_reset();
    src_mode  = 1;
    sink_mode = 1;
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({bif.gray_req, bif.lbp_valid, finish} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got req/valid/finish %b need 000", {bif.gray_req, bif.lbp_valid, finish});
    end
    n_tests++;
    if (bif.gray_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_gray_addr: got %0d need 0", bif.gray_addr);
    end
    n_tests++;
    if ({bif.lbp_addr, bif.lbp_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_lbp_out: got addr %0d data %02h need 0 0", bif.lbp_addr, bif.lbp_data);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (bif.gray_req !== 1'b1 || bif.gray_addr !== '0) begin
      n_fail++;
      $display("FAIL first_read: got req %b addr %0d need 1 0", bif.gray_req, bif.gray_addr);
    end
  endtask

  task automatic test_flat(input logic [7:0] t, input logic [7:0] want);
    int bad;
    src_mode  = 1;
    sink_mode = 1;
    fill_flat(8'd50);
    start_frame(t);
    finish_and_compare("flat");
    bad = 0;
    foreach (got_q[i]) if (got_q[i].data != want) bad++;
    n_tests++;
    if (bad != 0 || got_q.size() != NOUT) begin
      n_fail++;
      $display("FAIL flat_code thr=%0d: got %0d outputs with %0d not %02h need %0d all %02h",
               t, got_q.size(), bad, want, NOUT, want);
    end
    n_tests++;
    if (got_q.size() == 0 || got_q[0].addr !== AW'(IMG_W + 1) ||
        got_q[got_q.size()-1].addr !== AW'((IMG_H - 2) * IMG_W + IMG_W - 2)) begin
      n_fail++;
      $display("FAIL flat_addr_range: got %0d outputs need first %0d last %0d", got_q.size(),
               IMG_W + 1, (IMG_H - 2) * IMG_W + IMG_W - 2);
    end
  endtask

  task automatic test_pattern();
    src_mode  = 1;
    sink_mode = 1;
    fill_rand();
    img[0][0] = 8'd99;  img[0][1] = 8'd100; img[0][2] = 8'd101;
    img[1][0] = 8'd0;   img[1][1] = 8'd100; img[1][2] = 8'd255;
    img[2][0] = 8'd100; img[2][1] = 8'd50;  img[2][2] = 8'd200;
    start_frame(8'd0);
    finish_and_compare("pattern");
    n_tests++;
    if (got_q.size() == 0 || got_q[0] !== out_t'({AW'(IMG_W + 1), 8'hB6})) begin
      n_fail++;
      $display("FAIL pattern_code: got %0d outputs first %h need first addr %0d data b6",
               got_q.size(), got_q.size() ? got_q[0] : '0, IMG_W + 1);
    end
  endtask

  task automatic test_overflow();
    src_mode  = 1;
    sink_mode = 1;
    fill_flat(8'd255);
    img[1][1] = 8'd250;
    start_frame(8'd10);
    finish_and_compare("overflow_thr10");
    n_tests++;
    if (got_q.size() == 0 || got_q[0].data !== 8'h00) begin
      n_fail++;
      $display("FAIL overflow_thr10: got %0d outputs first data %02h need 00", got_q.size(),
               got_q.size() ? got_q[0].data : 8'h00);
    end
    start_frame(8'd5);
    finish_and_compare("overflow_thr5");
    n_tests++;
    if (got_q.size() == 0 || got_q[0].data !== 8'hFF) begin
      n_fail++;
      $display("FAIL edge_thr5: got %0d outputs first data %02h need ff", got_q.size(),
               got_q.size() ? got_q[0].data : 8'h00);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    src_mode  = 1;
    sink_mode = 1;
    fill_rand();
    start_frame(8'($urandom_range(0, 40)));
    finish_and_compare("back_to_back");
    n_tests++;
    if (valid_cyc.size() == 0 || valid_cyc[0] - req_first != 10) begin
      n_fail++;
      $display("FAIL first_latency: got %0d cycles need 10",
               valid_cyc.size() ? valid_cyc[0] - req_first : -1);
    end
    bad = 0;
    for (int i = 1; i < valid_cyc.size(); i++)
      if (valid_cyc[i] - valid_cyc[i-1] != ((i % (IMG_W - 2)) == 0 ? 11 : 5)) bad++;
    n_tests++;
    if (bad != 0 || valid_cyc.size() != NOUT) begin
      n_fail++;
      $display("FAIL pixel_gap: got %0d bad gaps over %0d outputs need 0 over %0d", bad,
               valid_cyc.size(), NOUT);
    end
  endtask

  task automatic test_random_stall();
    for (int r = 0; r < 2; r++) begin
      src_mode  = 2;
      sink_mode = 2;
      fill_rand();
      start_frame(8'($urandom_range(0, 255)));
      finish_and_compare("random_stall");
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    int bad;
    logic [AW-1:0] a;
    logic [7:0]    d;
    src_mode  = 1;
    sink_mode = 0;
    fill_rand();
    start_frame(8'($urandom_range(0, 30)));
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      seen = bif.lbp_valid;
    end
    sink_mode = 1;
    @(posedge clk); #1;
    sink_mode = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (!seen) begin
        @(posedge clk); #1;
        seen = bif.lbp_valid;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL bp_second_valid: got lbp_valid 0 need 1 within 100 cycles");
    end
    a = bif.lbp_addr;
    d = bif.lbp_data;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!bif.lbp_valid || bif.lbp_addr !== a || bif.lbp_data !== d || bif.gray_req) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d unstable cycles need 0", bad);
    end
    n_tests++;
    if (got_q.size() != 1 || out_t'({a, d}) !== exp_q[1]) begin
      n_fail++;
      $display("FAIL bp_held_value: got %0d accepted, held addr %0d data %02h need 1, addr %0d data %02h",
               got_q.size(), a, d, exp_q[1].addr, exp_q[1].data);
    end
    sink_mode = 1;
    finish_and_compare("backpressure");
  endtask

  task automatic test_midframe_reset();
    src_mode  = 1;
    sink_mode = 1;
    fill_rand();
    start_frame(8'($urandom_range(0, 20)));
    repeat (60) @(posedge clk);
    #1;
    n_tests++;
    if (got_q.size() == 0 || finish) begin
      n_fail++;
      $display("FAIL midframe_progress: got %0d outputs finish %b need >0 and 0", got_q.size(), finish);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if ({bif.gray_req, bif.lbp_valid, finish, bif.gray_addr, bif.lbp_addr, bif.lbp_data} !== '0) begin
      n_fail++;
      $display("FAIL midframe_reset_outputs: got req %b valid %b finish %b gaddr %0d laddr %0d data %02h need all 0",
               bif.gray_req, bif.lbp_valid, finish, bif.gray_addr, bif.lbp_addr, bif.lbp_data);
    end
    start_frame(8'($urandom_range(0, 20)));
    finish_and_compare("after_reset");
  endtask

  initial begin
    test_reset();
    test_flat(8'd0, 8'hFF);
    test_flat(8'd1, 8'h00);
    test_pattern();
    test_overflow();
    test_back_to_back();
    test_random_stall();
    test_backpressure();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
